axi_cmd_issuer: RTL and testbench
=================================

Name: axi_cmd_issuer

Overview:
- Initiator side of the Controller's command interface: buffers host commands and emits one-cycle `en` pulses with an `opcode` toward the Controller.
- Replaces hand-driven `en`/`opcode` stimulus in system builds.
- Enforces a per-slave (ALU/MEM/IO) outstanding-transaction credit limit, released by completion pulses from the Controller side.
- Issue is strictly in order; a stalled head entry blocks every entry behind it.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, ≥2)
- CNT_W, 4, width of `count` (must hold 0..DEPTH)
- MAX_OUT, 2, max outstanding transactions per slave (1..3)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- push  in  1  host enqueue strobe
- push_op  in  8  command: [7:4] ID; [3:2] target (01 ALU, 10 MEM, 11 IO); [1] R=0/W=1; [0] running bit
- push_err  out  1  one-cycle pulse: push rejected
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- count  out  CNT_W  current FIFO occupancy
- en  out  1  command strobe to Controller
- opcode  out  8  command to Controller, valid while en=1
- alu_done  in  1  one ALU transaction completed
- mem_done  in  1  one MEM transaction completed
- io_done  in  1  one IO transaction completed
- busy  out  1  FIFO non-empty or any outstanding count non-zero

Behaviour:
- All state updates on the rising clk edge.
- Reset (rst=0 at an edge):
  - FIFO flushed; pointers zeroed.
  - All three outstanding counters set to 0.
  - Outputs: en=0, opcode=0, push_err=0, count=0, empty=1, full=0, busy=0.
  - Reset asserted mid-operation drops queued and outstanding state with no further en pulses; done inputs in that cycle are ignored.
- FIFO:
  - Circular buffer with wrap-around pointers plus occupancy counter.
  - full/empty/count/busy are derived combinationally from registers.
- Push accepted when push=1, full=0 and push_op[3:2]≠00.
  - Push is rejected if full=1 at that edge, even if a pop happens in the same cycle.
  - Push is rejected if target=00.
  - A rejected push asserts push_err for exactly the next cycle; the entry is discarded.
- Bit 0 of every stored command is forced to 0 (waiting); all other bits are stored unchanged.
- Issue rule, evaluated each edge: FIFO non-empty and the head target's outstanding count < MAX_OUT → pop head.
  - The popped entry appears on opcode with en=1 in the following cycle, for exactly one cycle.
  - When no issue occurs: en=0 and opcode holds its last value.
- Back-to-back issue is allowed, one command per cycle maximum.
- Latency: push at edge N into an empty FIFO with credit available → en=1 in cycle N+1 → en=0 in cycle N+2 unless another entry issues.
- Ordering and blocking:
  - No reordering; a head entry stalled for credit blocks all later entries, including those for other targets.
- Counters (one per slave, 2 bits):
  - Issue to a target increments its counter.
  - xxx_done decrements it.
  - Issue and done for the same target in the same edge leave the counter unchanged.
  - done with counter=0 is ignored (no underflow).
  - A done pulse frees credit visible at the same edge it is sampled, so the head may issue on that edge.
- Simultaneous push and pop: both take effect; count unchanged.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (16 bits).
  - Increments on every edge where the FIFO is non-empty and the head is blocked by credit.
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 two edges with push=1, push_op=8'h34 → after release: count=0, empty=1, en=0, opcode=8'h00, busy=0.
- Single issue: push 8'h34 at edge N → en=1, opcode=8'h34 in cycle N+1 only; busy=1 until alu_done is pulsed.
- Credit stall (MAX_OUT=2):
  - Push 8'h34, 8'h36, 8'h34 on consecutive edges → two consecutive en pulses; third held, count=1.
  - Pulse alu_done → third issues next cycle, opcode=8'h34.
- Head-of-line blocking: ALU saturated, push 8'h34 then 8'h4A → 8'h4A not issued until alu_done; then en pulses 8'h34, then 8'h4A the following cycle.
- Full and invalid target:
  - With ALU saturated, push 8 ALU entries → full=1, count=8.
  - 9th push → push_err one cycle, count stays 8.
  - Push 8'h40 (target 00) when not full → push_err, not queued.
- Running-bit clear: push 8'h4F (IO, write, running) → issued opcode=8'h4E; with STALL_CNT_EN, a 5-cycle credit block gives stall_cnt=5.

Source files
------------

// File: rtl/axi_cmd_issuer_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_cmd_issuer_if
// Description : Host-push, Controller-issue and completion signals of the
//               command issuer, bundled with master (issuer) and slave
//               (host/Controller) views. stall_cnt exists only when
//               STALL_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_cmd_issuer_if #(
  parameter int CNT_W = 4
);
  logic             push;
  logic [7:0]       push_op;
  logic             push_err;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             en;
  logic [7:0]       opcode;
  logic             alu_done;
  logic             mem_done;
  logic             io_done;
  logic             busy;
`ifdef STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  // Issuer side: consumes host pushes and completions, drives everything else
  modport master (
    input  push, push_op, alu_done, mem_done, io_done,
    output push_err, full, empty, count, en, opcode, busy
`ifdef STALL_CNT_EN
    , output stall_cnt
`endif
  );

  // Host/Controller side: the mirror image of the issuer view
  modport slave (
    output push, push_op, alu_done, mem_done, io_done,
    input  push_err, full, empty, count, en, opcode, busy
`ifdef STALL_CNT_EN
    , input stall_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/axi_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : axi_cmd_issuer
// Description : In-order command FIFO that issues one-cycle en/opcode pulses
//               toward the Controller, limited by a per-slave (ALU/MEM/IO)
//               outstanding-transaction credit released by done pulses.
//               Optional macro STALL_CNT_EN adds a saturating 16-bit count of
//               edges on which the head entry was blocked by credit.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_cmd_issuer #(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 4,
  parameter int MAX_OUT = 2
) (
  input  wire logic           clk,
  input  wire logic           rst,
  axi_cmd_issuer_if.master    bus
);

  localparam int         c_PTR_W   = $clog2(DEPTH);
  localparam logic [1:0] c_MAX_OUT = 2'(MAX_OUT);

  // Storage and pointers
  logic [7:0]         r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  // Outstanding counters: index 0 = ALU, 1 = MEM, 2 = IO (target code - 1)
  logic [1:0]         r_out_cnt [3];

  // Registered outputs
  logic               r_en;
  logic [7:0]         r_opcode;
  logic               r_push_err;

  logic               w_full;
  logic               w_empty;
  logic [7:0]         w_head;
  logic [7:0]         w_push_cmd;
  logic               w_push_ok;
  logic               w_pop;
  logic               w_credit_ok;
  logic [2:0]         w_done;
  logic [2:0]         w_dec;
  logic [2:0]         w_room;
  logic [2:0]         w_tgt_hit;
  logic [2:0]         w_issue;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_head     = r_mem[r_rd_ptr];
  // The running bit is always stored cleared: queued commands are waiting
  assign w_push_cmd = bus.push_op & 8'hFE;
  assign w_push_ok  = bus.push && !w_full && (bus.push_op[3:2] != 2'b00);
  assign w_done     = {bus.io_done, bus.mem_done, bus.alu_done};

  // Per-slave credit check; a done sampled this edge already frees its slot
  always_comb begin
    w_tgt_hit = '0;
    w_dec     = '0;
    w_room    = '0;
    for (int i = 0; i < 3; i++) begin
      w_tgt_hit[i] = (w_head[3:2] == 2'(i + 1));
      w_dec[i]     = w_done[i] && (r_out_cnt[i] != 2'd0);
      w_room[i]    = ((r_out_cnt[i] - {1'b0, w_dec[i]}) < c_MAX_OUT);
    end
  end

  assign w_credit_ok = |(w_tgt_hit & w_room);
  assign w_pop       = !w_empty && w_credit_ok;
  assign w_issue     = w_pop ? w_tgt_hit : 3'b000;

  // FIFO pointers and occupancy; simultaneous push and pop keep count steady
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
    end
  end

  // Entry storage; contents need no reset because the pointers gate reads
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_push_cmd;
  end

  // Outstanding counters: issue adds, done subtracts, both together cancel
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) r_out_cnt[i] <= 2'd0;
      else      r_out_cnt[i] <= r_out_cnt[i] + {1'b0, w_issue[i]} - {1'b0, w_dec[i]};
    end
  end

  // Issue strobe, held opcode and one-cycle push rejection pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_en       <= 1'b0;
      r_opcode   <= 8'h00;
      r_push_err <= 1'b0;
    end else begin
      r_en       <= w_pop;
      if (w_pop) r_opcode <= w_head;
      r_push_err <= bus.push && !w_push_ok;
    end
  end

`ifdef STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Counts edges where a queued head waits for credit, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= 16'h0000;
    end else if (!w_empty && !w_credit_ok && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`endif

  assign bus.en       = r_en;
  assign bus.opcode   = r_opcode;
  assign bus.push_err = r_push_err;
  assign bus.count    = r_count;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.busy     = !w_empty || (r_out_cnt[0] != 2'd0) ||
                        (r_out_cnt[1] != 2'd0) || (r_out_cnt[2] != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_axi_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_cmd_issuer
// Description : Self-checking bench for axi_cmd_issuer: a queue-based model
//               of the command rules checked every cycle, plus directed
//               scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_cmd_issuer;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
  localparam int MAX_OUT = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  axi_cmd_issuer_if #(.CNT_W(CNT_W)) bus ();

  axi_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_OUT(MAX_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_q[$];
  int         m_out[4];
  logic       m_en;
  logic [7:0] m_op;
  logic       m_err;
  int         m_stall;
  bit         m_valid;

  always @(posedge clk) begin
    m_valid = 1'b1;
    if (!rst) begin
      m_q.delete();
      for (int t = 0; t < 4; t++) m_out[t] = 0;
      m_en = 0; m_op = 8'h00; m_err = 0; m_stall = 0;
    end else begin
      bit was_full;
      bit can_issue;
      int tg;
      was_full = (m_q.size() == DEPTH);
      if (bus.alu_done && m_out[1] > 0) m_out[1]--;
      if (bus.mem_done && m_out[2] > 0) m_out[2]--;
      if (bus.io_done  && m_out[3] > 0) m_out[3]--;
      can_issue = 0;
      tg = 0;
      if (m_q.size() > 0) begin
        tg = int'(m_q[0][3:2]);
        can_issue = (m_out[tg] < MAX_OUT);
        if (!can_issue && m_stall < 65535) m_stall++;
      end
      if (can_issue) begin
        m_op = m_q.pop_front();
        m_out[tg]++;
        m_en = 1;
      end else begin
        m_en = 0;
      end
      if (bus.push && !was_full && bus.push_op[3:2] != 2'b00) begin
        m_q.push_back(bus.push_op & 8'hFE);
        m_err = 0;
      end else begin
        m_err = bus.push;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("en",       32'(bus.en),       32'(m_en));
      chk("opcode",   32'(bus.opcode),   32'(m_op));
      chk("push_err", 32'(bus.push_err), 32'(m_err));
      chk("count",    32'(bus.count),    32'(m_q.size()));
      chk("empty",    32'(bus.empty),    32'(m_q.size() == 0));
      chk("full",     32'(bus.full),     32'(m_q.size() == DEPTH));
      chk("busy",     32'(bus.busy),
          32'((m_q.size() != 0) || (m_out[1] != 0) || (m_out[2] != 0) || (m_out[3] != 0)));
`ifdef STALL_CNT_EN
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
`endif
    end
  end

  // One clock: apply inputs, let an edge pass, return at the next falling edge
  task automatic cyc(input logic p, input logic [7:0] op,
                     input logic a, input logic m, input logic i);
    bus.push = p; bus.push_op = op;
    bus.alu_done = a; bus.mem_done = m; bus.io_done = i;
    @(posedge clk);
    @(negedge clk);
    bus.push = 1'b0; bus.alu_done = 1'b0; bus.mem_done = 1'b0; bus.io_done = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; m_valid = 0;
    m_en = 0; m_op = 0; m_err = 0; m_stall = 0;
    for (int t = 0; t < 4; t++) m_out[t] = 0;
    rst = 1'b0;
    bus.push = 1'b1; bus.push_op = 8'h34;
    bus.alu_done = 1'b0; bus.mem_done = 1'b0; bus.io_done = 1'b0;

    // Reset held two edges while pushing
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count",  32'(bus.count),  32'd0);
    chk("rst_empty",  32'(bus.empty),  32'd1);
    chk("rst_en",     32'(bus.en),     32'd0);
    chk("rst_opcode", 32'(bus.opcode), 32'h00);
    chk("rst_busy",   32'(bus.busy),   32'd0);
    bus.push = 1'b0;
    rst = 1'b1;

    // Single issue
    cyc(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    chk("single_queued_en", 32'(bus.en),    32'd0);
    chk("single_count",     32'(bus.count), 32'd1);
    idle();
    chk("single_en",     32'(bus.en),     32'd1);
    chk("single_opcode", 32'(bus.opcode), 32'h34);
    idle();
    chk("single_en_drop", 32'(bus.en),     32'd0);
    chk("single_op_hold", 32'(bus.opcode), 32'h34);
    chk("single_busy",    32'(bus.busy),   32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("single_idle_busy", 32'(bus.busy), 32'd0);

    // Credit stall on ALU
    cyc(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h36, 1'b0, 1'b0, 1'b0);
    chk("stall_first_en", 32'(bus.en),     32'd1);
    chk("stall_first_op", 32'(bus.opcode), 32'h34);
    cyc(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    chk("stall_second_op", 32'(bus.opcode), 32'h36);
    idle();
    chk("stall_held_en",    32'(bus.en),    32'd0);
    chk("stall_held_count", 32'(bus.count), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("stall_release_en", 32'(bus.en),     32'd1);
    chk("stall_release_op", 32'(bus.opcode), 32'h34);

    // Head-of-line blocking (ALU saturated)
    cyc(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h4A, 1'b0, 1'b0, 1'b0);
    idle();
    chk("hol_blocked_en", 32'(bus.en),    32'd0);
    chk("hol_count",      32'(bus.count), 32'd2);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("hol_first_op", 32'(bus.opcode), 32'h34);
    idle();
    chk("hol_second_en", 32'(bus.en),     32'd1);
    chk("hol_second_op", 32'(bus.opcode), 32'h4A);

    // Fill with blocked ALU entries
    for (int k = 0; k < DEPTH; k++) cyc(1'b1, 8'(8'h14 + 8'(k << 4)), 1'b0, 1'b0, 1'b0);
    chk("full_flag",  32'(bus.full),  32'd1);
    chk("full_count", 32'(bus.count), 32'd8);
    cyc(1'b1, 8'h24, 1'b0, 1'b0, 1'b0);
    chk("full_err",   32'(bus.push_err), 32'd1);
    chk("full_count_kept", 32'(bus.count), 32'd8);
    idle();
    chk("err_one_cycle", 32'(bus.push_err), 32'd0);
    // Push while full with a same-edge pop is still rejected
    cyc(1'b1, 8'h24, 1'b1, 1'b0, 1'b0);
    chk("full_pop_err",   32'(bus.push_err), 32'd1);
    chk("full_pop_count", 32'(bus.count),    32'd7);
    // Invalid target
    cyc(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
    chk("tgt00_err",   32'(bus.push_err), 32'd1);
    chk("tgt00_count", 32'(bus.count),    32'd7);
    for (int k = 0; k < 7; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Reset mid-operation with a done pulse ignored
    cyc(1'b1, 8'h18, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("midrst_busy",  32'(bus.busy),  32'd0);
    chk("midrst_count", 32'(bus.count), 32'd0);
    rst = 1'b1;

    // Running-bit clear and IO credit stall
    cyc(1'b1, 8'h4F, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h4F, 1'b0, 1'b0, 1'b0);
    chk("runbit_en", 32'(bus.en),     32'd1);
    chk("runbit_op", 32'(bus.opcode), 32'h4E);
    cyc(1'b1, 8'h4F, 1'b0, 1'b0, 1'b0);
    repeat (5) idle();
    chk("io_block_en", 32'(bus.en), 32'd0);
`ifdef STALL_CNT_EN
    chk("stall_cnt_5", 32'(bus.stall_cnt), 32'd5);
`endif
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("io_release_op", 32'(bus.opcode), 32'h4E);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (2) idle();
    chk("end_busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
